// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: op classes, R-type funct
// codes, datapath operation codes and FSM states.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_SUBI  = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_BEQ   = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_ADDU = 6'h0B;
  localparam logic [5:0] FN_SUBU = 6'h0D;
  localparam logic [5:0] FN_AND  = 6'h12;
  localparam logic [5:0] FN_SLL  = 6'h26;

  localparam logic [5:0] OP_ADDU = 6'h09;
  localparam logic [5:0] OP_SUBU = 6'h0A;
  localparam logic [5:0] OP_AND  = 6'h11;
  localparam logic [5:0] OP_SLL  = 6'h21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_control_seq_if.sv
// Request/result bundle between the requester/consumer and the ALU control sequencer.
interface alu_control_seq_if #(
  parameter int FUNCT_W = 6,
  parameter int SHAMT_W = 5
);
  logic               valid_i;
  logic               ready_o;
  logic [1:0]         ALUOp;
  logic [FUNCT_W-1:0] funct;
  logic [SHAMT_W-1:0] shamt;
  logic [FUNCT_W-1:0] Funct1;
  logic               step_o;
  logic               valid_o;
  logic               ready_i;
  logic               illegal_o;

  modport master (
    output valid_i, ALUOp, funct, shamt, ready_i,
    input  ready_o, Funct1, step_o, valid_o, illegal_o
  );

  modport slave (
    input  valid_i, ALUOp, funct, shamt, ready_i,
    output ready_o, Funct1, step_o, valid_o, illegal_o
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational decode of op class and funct field into a datapath operation
// code, an SLL flag and an illegal-encoding flag.
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [FUNCT_W-1:0] code,
  output logic               is_sll,
  output logic               illegal
);

  // op class / funct lookup
  always_comb begin
    code    = {FUNCT_W{1'b0}};
    is_sll  = 1'b0;
    illegal = 1'b0;
    case (aluop_e'(alu_op))
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_W'(FN_ADDU): code = FUNCT_W'(OP_ADDU);
          FUNCT_W'(FN_SUBU): code = FUNCT_W'(OP_SUBU);
          FUNCT_W'(FN_AND):  code = FUNCT_W'(OP_AND);
          FUNCT_W'(FN_SLL): begin
            code   = FUNCT_W'(OP_SLL);
            is_sll = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_MEM:  code = FUNCT_W'(OP_ADDU);
      ALUOP_SUBI: code = FUNCT_W'(OP_SUBU);
      ALUOP_BEQ:  code = FUNCT_W'(OP_SUBU);
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: decodes a request and, for SLL, issues one shift
// strobe per bit of shift amount before presenting the final operation code.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  alu_control_seq_if.slave   bus
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_e             state_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic [FUNCT_W-1:0] funct1_r;
  logic               step_r;
  logic               valid_r;
  logic               illegal_r;

  logic [FUNCT_W-1:0] dec_code_s;
  logic               dec_sll_s;
  logic               dec_illegal_s;
  logic               ready_s;
  logic               accept_s;

  alu_decode #(.FUNCT_W(FUNCT_W)) u_decode (
    .alu_op  (bus.ALUOp),
    .funct   (bus.funct),
    .code    (dec_code_s),
    .is_sll  (dec_sll_s),
    .illegal (dec_illegal_s)
  );

  // in OUT the consumer's ready passes through so a new request overlaps the handoff
  assign ready_s  = (state_r == ST_IDLE) || ((state_r == ST_OUT) && bus.ready_i);
  assign accept_s = bus.valid_i && ready_s;

  // sequencer state, shift counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      funct1_r  <= {FUNCT_W{1'b0}};
      step_r    <= 1'b0;
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OUT: begin
          if (accept_s) begin
            funct1_r  <= dec_code_s;
            illegal_r <= dec_illegal_s;
            if (dec_sll_s && (bus.shamt != CNT_ZERO)) begin
              state_r <= ST_SHIFT;
              cnt_r   <= bus.shamt;
              step_r  <= 1'b1;
              valid_r <= 1'b0;
            end else begin
              state_r <= ST_OUT;
              cnt_r   <= CNT_ZERO;
              step_r  <= 1'b0;
              valid_r <= 1'b1;
            end
          end else if ((state_r == ST_OUT) && bus.ready_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            funct1_r  <= {FUNCT_W{1'b0}};
            step_r    <= 1'b0;
            valid_r   <= 1'b0;
            illegal_r <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SHIFT: begin
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_OUT;
            cnt_r   <= CNT_ZERO;
            step_r  <= 1'b0;
            valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= CNT_ZERO;
          funct1_r  <= {FUNCT_W{1'b0}};
          step_r    <= 1'b0;
          valid_r   <= 1'b0;
          illegal_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o   = ready_s;
  assign bus.Funct1    = funct1_r;
  assign bus.step_o    = step_r;
  assign bus.valid_o   = valid_r;
  assign bus.illegal_o = illegal_r;

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized self-checking bench for alu_control_seq against a transaction-level
// reference model (decode table, step count and latency per request).
module tb_alu_control_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  bit   in_out;

  int fn_tab [4] = '{11, 13, 18, 38};
  int cd_tab [4] = '{9, 10, 17, 33};

  alu_control_seq_if #(.FUNCT_W(6), .SHAMT_W(5)) bus ();

  alu_control_seq #(.FUNCT_W(6), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: what the request should produce, independent of any state encoding.
  task automatic ref_model(input int op, input int fn, input int sh,
                           output int code, output int ill, output int steps);
    code  = 0;
    ill   = 0;
    steps = 0;
    if (op == 2) begin
      ill = 1;
      for (int i = 0; i < 4; i++) begin
        if (fn == fn_tab[i]) begin
          code = cd_tab[i];
          ill  = 0;
        end
      end
      if (fn == 38) steps = sh;
    end else if (op == 0) begin
      code = 9;
    end else begin
      code = 10;
    end
  endtask

  // Called at a negedge with the DUT idle or holding a previous result.
  task automatic do_txn(input int op, input int fn, input int sh, input int stall, input bit release_after);
    int exp_code, exp_ill, exp_steps, cyc, steps;
    bit got, bad_code;
    ref_model(op, fn, sh, exp_code, exp_ill, exp_steps);
    bus.valid_i = 1'b1;
    bus.ALUOp   = 2'(op);
    bus.funct   = 6'(fn);
    bus.shamt   = 5'(sh);
    bus.ready_i = 1'b1;
    #1 chk("ready_at_accept", 32'(bus.ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.ALUOp   = 2'($urandom_range(3, 0));
    bus.funct   = 6'($urandom_range(63, 0));
    bus.shamt   = 5'($urandom_range(31, 0));
    cyc = 1; steps = 0; got = 1'b0; bad_code = 1'b0;
    while (!got && cyc <= 40) begin
      if (bus.step_o) begin
        steps++;
        if (bus.Funct1 != 6'h21) bad_code = 1'b1;
      end
      if (bus.valid_o) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("valid_timeout", 32'(got), 32'd1);
    if (!got) return;
    chk("latency", 32'(cyc), 32'(exp_steps + 1));
    chk("step_count", 32'(steps), 32'(exp_steps));
    chk("shift_code", 32'(bad_code), 32'd0);
    chk("funct1", 32'(bus.Funct1), 32'(exp_code));
    chk("illegal", 32'(bus.illegal_o), 32'(exp_ill));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.valid_o), 32'd1);
      chk("hold_funct1", 32'(bus.Funct1), 32'(exp_code));
      chk("hold_ready", 32'(bus.ready_o), 32'd0);
    end
    if (release_after) begin
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
      #1;
      chk("idle_valid", 32'(bus.valid_o), 32'd0);
      chk("idle_funct1", 32'(bus.Funct1), 32'd0);
      chk("idle_illegal", 32'(bus.illegal_o), 32'd0);
      chk("idle_ready", 32'(bus.ready_o), 32'd1);
      in_out = 1'b0;
    end else begin
      in_out = 1'b1;
    end
  endtask

  initial begin
    int op, fn, sh, steps, guard;
    bit stray;
    n_vec = 0; n_miss = 0; in_out = 1'b0;
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    bus.ALUOp = 2'b00; bus.funct = 6'h00; bus.shamt = 5'd0;
    @(negedge clk);
    chk("rst_funct1", 32'(bus.Funct1), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_step", 32'(bus.step_o), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
    rst = 1'b0;
    #1 chk("rst_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);

    do_txn(2, 'h0B, 0, 0, 1'b1);
    do_txn(2, 'h26, 3, 0, 1'b1);
    do_txn(2, 'h3F, 0, 1, 1'b1);
    do_txn(3, 'h00, 0, 0, 1'b1);
    do_txn(2, 'h12, 7, 5, 1'b0);
    do_txn(1, 'h0D, 0, 2, 1'b0);
    do_txn(2, 'h26, 0, 0, 1'b1);
    do_txn(2, 'h26, 31, 0, 1'b1);
    do_txn(0, 'h26, 9, 0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(3, 0);
      fn = ($urandom_range(1, 0) == 1) ? fn_tab[$urandom_range(3, 0)] : $urandom_range(63, 0);
      sh = ($urandom_range(3, 0) == 0) ? $urandom_range(31, 0) : $urandom_range(6, 0);
      do_txn(op, fn, sh, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    if (in_out) begin
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
    end

    // reset in the middle of a long shift
    bus.valid_i = 1'b1; bus.ALUOp = 2'b10; bus.funct = 6'h26; bus.shamt = 5'd20;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    steps = 0; guard = 0;
    while (steps < 4 && guard < 10) begin
      if (bus.step_o) steps++;
      if (steps < 4) @(negedge clk);
      guard++;
    end
    chk("pre_rst_steps", 32'(steps), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("arst_step", 32'(bus.step_o), 32'd0);
    chk("arst_valid", 32'(bus.valid_o), 32'd0);
    chk("arst_funct1", 32'(bus.Funct1), 32'd0);
    chk("arst_illegal", 32'(bus.illegal_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_ready", 32'(bus.ready_o), 32'd1);
    stray = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.step_o || bus.valid_o) stray = 1'b1;
    end
    chk("abandoned", 32'(stray), 32'd0);
    do_txn(2, 'h0D, 0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
